// File: rtl/sync_channel_pkg.sv
// Shared types and helpers for the clocked receiver of the signed-data channel.
package sync_channel_pkg;

  typedef enum logic [1:0] {
    StWaitNeutral = 2'd0,
    StIdle        = 2'd1,
    StReq         = 2'd2
  } state_e;

  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultDepth      = 2;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/chan_valid_sync.sv
// Flop-chain synchroniser for channel validity, plus a marker that tells when the chain
// holds real samples rather than its reset value.
module chan_valid_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_primed
);

  logic [SyncStages-1:0] r_chain;
  logic [SyncStages-1:0] r_prime;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain <= '0;
      r_prime <= '0;
    end else begin
      r_chain <= {r_chain[SyncStages-2:0], i_async};
      r_prime <= {r_prime[SyncStages-2:0], 1'b1};
    end
  end

  assign o_sync   = r_chain[SyncStages-1];
  assign o_primed = r_prime[SyncStages-1];

endmodule

// File: rtl/sync_channel_receiver.sv
// Receives tokens from an asynchronous signed-data channel sender and presents them as a
// valid/ready stream through a small FIFO.
module sync_channel_receiver
  import sync_channel_pkg::*;
#(
  parameter int unsigned BitWidth   = 8,
  parameter int unsigned Depth      = DefaultDepth,
  parameter int unsigned SyncStages = DefaultSyncStages
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic signed [BitWidth:0]   i_l_data,
  output logic                       o_l_enable,
  output logic [BitWidth-1:0]        o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [$clog2(Depth+1)-1:0] o_count,
  output logic                       o_proto_err
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  state_e              r_state;
  state_e              w_state_d;
  logic                w_valid_s;
  logic                w_primed;
  logic                w_pop;
  logic                w_capture;
  logic                w_space;
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic                r_proto_err;
  logic [BitWidth-1:0] r_mem [Depth];

  chan_valid_sync #(
    .SyncStages(SyncStages)
  ) u_valid_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (~i_l_data[BitWidth]),
    .o_sync  (w_valid_s),
    .o_primed(w_primed)
  );

  assign w_pop     = (r_count != '0) && i_out_ready;
  assign w_capture = (r_state == StReq) && w_valid_s;
  assign w_space   = (r_count < CntW'(Depth)) || w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StWaitNeutral;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Leaving WaitNeutral needs a primed chain, so a token held across reset is not
  // mistaken for neutral by the freshly cleared synchroniser.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StWaitNeutral: if (w_primed && !w_valid_s) w_state_d = StIdle;
      StIdle: begin
        if (w_valid_s)    w_state_d = StWaitNeutral;
        else if (w_space) w_state_d = StReq;
      end
      StReq:   if (w_valid_s) w_state_d = StWaitNeutral;
      default: w_state_d = StWaitNeutral;
    endcase
  end

  always_comb begin
    o_l_enable = (r_state == StReq);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_capture) r_wr_ptr <= PtrW'(ptr_inc(32'(r_wr_ptr), Depth));
      if (w_pop)     r_rd_ptr <= PtrW'(ptr_inc(32'(r_rd_ptr), Depth));
      if (w_capture && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_capture && w_pop) r_count <= r_count - 1'b1;
      if ((r_state == StIdle) && w_valid_s) r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture && !i_reset) r_mem[r_wr_ptr] <= i_l_data[BitWidth-1:0];
  end

  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_out_valid = (r_count != '0);
  assign o_count     = r_count;
  assign o_proto_err = r_proto_err;

endmodule
